// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcode constants, forward-select encodings and stage control record for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] AUIPC  = 5'b00101;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stage_ctrl_t;

    function automatic logic writes_rd(input logic [4:0] opcode);
        return !(opcode == BRANCH || opcode == STORE);
    endfunction

    function automatic logic uses_rs1(input logic [4:0] opcode);
        return opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
    endfunction

    function automatic logic uses_rs2(input logic [4:0] opcode);
        return opcode inside {OP, STORE, BRANCH};
    endfunction

    // True when a producer writing wr_rd feeds a source register the consumer actually reads.
    function automatic logic raw_dep(input logic wr_valid, input logic [4:0] wr_rd,
                                     input logic [4:0] opcode, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        return wr_valid && (wr_rd != 5'd0) &&
               ((uses_rs1(opcode) && wr_rd == rs1) || (uses_rs2(opcode) && wr_rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// rtl/pipe_ctrl_hazard_unit.sv - stall and E-stage forward selection; FORWARDING_EN enables M/W forwarding
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  stage_ctrl_t e_ctrl,
    input  stage_ctrl_t m_ctrl,
    input  logic [4:0]  d_opcode,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        w_wb_en,
    input  logic [4:0]  w_rd,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  e_rs1_fwd_sel,
    output logic [1:0]  e_rs2_fwd_sel
);

    logic hazard;

`ifdef FORWARDING_EN
    logic m_fwd_ok;
    logic unused_m;

    assign m_fwd_ok = m_ctrl.valid && writes_rd(m_ctrl.opcode) && (m_ctrl.rd != 5'd0);
    assign unused_m = ^{m_ctrl.rs1, m_ctrl.rs2};

    // Only a load result is too late to forward from M into E.
    assign hazard = e_ctrl.valid && (e_ctrl.opcode == LOAD) &&
                    raw_dep(1'b1, e_ctrl.rd, d_opcode, d_rs1, d_rs2);

    always_comb begin
        e_rs1_fwd_sel = FWD_RF;
        e_rs2_fwd_sel = FWD_RF;
        if (m_fwd_ok && m_ctrl.rd == e_ctrl.rs1)
            e_rs1_fwd_sel = FWD_M;
        else if (w_wb_en && w_rd == e_ctrl.rs1)
            e_rs1_fwd_sel = FWD_W;
        if (m_fwd_ok && m_ctrl.rd == e_ctrl.rs2)
            e_rs2_fwd_sel = FWD_M;
        else if (w_wb_en && w_rd == e_ctrl.rs2)
            e_rs2_fwd_sel = FWD_W;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{e_ctrl.rs1, e_ctrl.rs2, m_ctrl.rs1, m_ctrl.rs2, w_wb_en, w_rd};

    // Without forwarding every in-flight producer in E or M blocks the reader; W is bypassed in D.
    assign hazard = raw_dep(e_ctrl.valid && writes_rd(e_ctrl.opcode), e_ctrl.rd,
                            d_opcode, d_rs1, d_rs2) ||
                    raw_dep(m_ctrl.valid && writes_rd(m_ctrl.opcode), m_ctrl.rd,
                            d_opcode, d_rs1, d_rs2);

    assign e_rs1_fwd_sel = FWD_RF;
    assign e_rs2_fwd_sel = FWD_RF;
`endif

    // A redirect discards the dependent instruction, so it must not also hold the front end.
    assign stall = hazard && !flush;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - E/M/W control pipeline, datapath selects and redirect; FORWARDING_EN selects hazard policy
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_opcode,
    input  logic [4:0] D_rd,
    input  logic [4:0] D_rs1,
    input  logic [4:0] D_rs2,
    input  logic       b,
    output logic       next_pc_sel,
    output logic       stall,
    output logic       flush,
    output logic       E_alu_op1_sel,
    output logic       E_alu_op2_sel,
    output logic       E_jb_op1_sel,
    output logic       W_wb_data_sel,
    output logic       W_wb_en,
    output logic [4:0] W_rd,
    output logic       D_rs1_data_sel,
    output logic       D_rs2_data_sel,
    output logic [1:0] E_rs1_fwd_sel,
    output logic [1:0] E_rs2_fwd_sel
);

    stage_ctrl_t d_ctrl;
    stage_ctrl_t e_q;
    stage_ctrl_t m_q;
    stage_ctrl_t w_q;
    logic        unused_w;

    assign d_ctrl = '{valid: 1'b1, opcode: D_opcode, rd: D_rd, rs1: D_rs1, rs2: D_rs2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= (stall || flush) ? '0 : d_ctrl;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    assign next_pc_sel = e_q.valid &&
                         (e_q.opcode == JAL || e_q.opcode == JALR ||
                          (e_q.opcode == BRANCH && b));
    assign flush       = next_pc_sel;

    // Selects are qualified by valid so bubbles and reset decode to zero.
    assign E_alu_op1_sel = e_q.valid && !(e_q.opcode inside {AUIPC, JAL, JALR});
    assign E_alu_op2_sel = e_q.valid && (e_q.opcode inside {OP, BRANCH});
    assign E_jb_op1_sel  = e_q.valid && (e_q.opcode == JALR);

    assign W_wb_data_sel = w_q.valid && (w_q.opcode == LOAD);
    assign W_wb_en       = w_q.valid && writes_rd(w_q.opcode) && (w_q.rd != 5'd0);
    assign W_rd          = w_q.rd;
    assign unused_w      = ^{w_q.rs1, w_q.rs2};

    assign D_rs1_data_sel = W_wb_en && (w_q.rd == D_rs1);
    assign D_rs2_data_sel = W_wb_en && (w_q.rd == D_rs2);

    hazard_unit u_hazard_unit (
        .e_ctrl        (e_q),
        .m_ctrl        (m_q),
        .d_opcode      (D_opcode),
        .d_rs1         (D_rs1),
        .d_rs2         (D_rs2),
        .w_wb_en       (W_wb_en),
        .w_rd          (w_q.rd),
        .flush         (flush),
        .stall         (stall),
        .e_rs1_fwd_sel (E_rs1_fwd_sel),
        .e_rs2_fwd_sel (E_rs2_fwd_sel)
    );

endmodule
